// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg: shared types for the data-side bus bridge
package dmem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        DB_IDLE = 2'd0,
        DB_REQ  = 2'd1,
        DB_WAIT = 2'd2,
        DB_DONE = 2'd3
    } db_state_e;

endpackage

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: MEM-stage request to SRAM-like req/addr_ok/data_ok bus master with pipeline stall; define DMEM_WBUF_EN to post stores
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_ce_i,
    input  logic          mem_we_i,
    input  logic [3:0]    mem_sel_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic          exc_flush_i,
    output logic [DW-1:0] rdata_o,
    output logic          stall_req_o,
    output logic          dbus_req_o,
    output logic          dbus_wr_o,
    output logic [3:0]    dbus_wstrb_o,
    output logic [AW-1:0] dbus_addr_o,
    output logic [DW-1:0] dbus_wdata_o,
    input  logic          dbus_addr_ok_i,
    input  logic          dbus_data_ok_i,
    input  logic [DW-1:0] dbus_rdata_i
);

    db_state_e     state_q, state_d;
    logic          drop_q, drop_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          issue;
    logic          blocked;
    logic          posted;
    logic          unused_addr_lsb;

    assign issue           = mem_ce_i & |mem_sel_i & ~exc_flush_i;
    assign unused_addr_lsb = ^mem_addr_i[1:0];
    assign rdata_o         = rdata_q;
    assign dbus_req_o      = state_q == DB_REQ;
    assign dbus_wr_o       = dbus_req_o & we_q;
    assign dbus_wstrb_o    = sel_q;
    assign dbus_addr_o     = addr_q;
    assign dbus_wdata_o    = wdata_q;

`ifdef DMEM_WBUF_EN
    logic wbuf_pend_q, wbuf_pend_d;
    assign blocked = wbuf_pend_q;
    assign posted  = we_q;
    // A posted store stays pending from its acceptance until its data_ok
    always_comb wbuf_pend_d = (dbus_req_o && we_q && dbus_addr_ok_i) ? 1'b1 :
                              (dbus_data_ok_i ? 1'b0 : wbuf_pend_q);
    // Write-buffer pending flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wbuf_pend_q <= 1'b0;
        else      wbuf_pend_q <= wbuf_pend_d;
    end
`else
    assign blocked = 1'b0;
    assign posted  = 1'b0;
`endif

    // Next state, request latching, read capture and stall generation
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        stall_req_o = 1'b0;
        unique case (state_q)
            DB_IDLE: begin
                stall_req_o = issue;
                if (issue && !blocked) begin
                    state_d = DB_REQ;
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    addr_d  = {mem_addr_i[AW-1:2], 2'b00};
                    wdata_d = mem_wdata_i;
                end
            end
            DB_REQ: begin
                drop_d = drop_q | exc_flush_i;
                if (dbus_addr_ok_i) state_d = posted ? (drop_d ? DB_IDLE : DB_DONE) : DB_WAIT;
            end
            DB_WAIT: begin
                drop_d = drop_q | exc_flush_i;
                if (dbus_data_ok_i) begin
                    state_d = drop_d ? DB_IDLE : DB_DONE;
                    rdata_d = (!we_q && !drop_d) ? dbus_rdata_i : rdata_q;
                end
            end
            DB_DONE: state_d = DB_IDLE;
        endcase
        if (state_q == DB_REQ || state_q == DB_WAIT) stall_req_o = drop_d ? issue : 1'b1;
        if (state_d == DB_IDLE) drop_d = 1'b0;
    end

    // State and request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DB_IDLE;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: scoreboard bench with a randomized bus slave and a word-memory reference model
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ce_i = 1'b0, mem_we_i = 1'b0, exc_flush_i = 1'b0;
    logic [3:0]  mem_sel_i = 4'b0;
    logic [31:0] mem_addr_i = 32'b0, mem_wdata_i = 32'b0;
    logic [31:0] rdata_o;
    logic        stall_req_o, dbus_req_o, dbus_wr_o;
    logic [3:0]  dbus_wstrb_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic        dbus_addr_ok_i, dbus_data_ok_i;
    logic [31:0] dbus_rdata_i;

    always #5 clk = ~clk;

    dmem_bus_bridge dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .exc_flush_i(exc_flush_i),
        .rdata_o(rdata_o), .stall_req_o(stall_req_o),
        .dbus_req_o(dbus_req_o), .dbus_wr_o(dbus_wr_o), .dbus_wstrb_o(dbus_wstrb_o),
        .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_addr_ok_i(dbus_addr_ok_i), .dbus_data_ok_i(dbus_data_ok_i), .dbus_rdata_i(dbus_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rmem[logic [31:0]];
    logic [31:0] smem[logic [31:0]];
    logic [31:0] last_rd = 32'b0;
    int tests = 0, fails = 0;
    int aok_fix = 0, dok_fix = 0;
    int req_cycles = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m = 32'b0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i+:8] = 8'hff;
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
        return (old & ~lane_mask(s)) | (wd & lane_mask(s));
    endfunction

    function automatic logic [31:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] sget(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one MEM request (caller is just after a posedge), updates the reference model,
    // holds it while stalled and returns the number of stalled cycles.
    task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wd, output int stalls);
        bus_t        b;
        logic [31:0] wa;
        bit          done = 0;
        wa = {addr[31:2], 2'b00};
        mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_wdata_i = wd;
        if (|sel) begin
            b.addr = wa; b.wr = we; b.strb = sel; b.wdata = wd;
            exp_bus.push_back(b);
            if (we) rmem[wa] = merge(rget(wa), wd, sel);
            else last_rd = rget(wa);
            exp_rd.push_back(last_rd);
        end
        stalls = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stall_req_o) stalls++;
            else done = 1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL access_timeout: addr %h still stalled after 100 cycles", addr);
        end
        @(posedge clk); #1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'b0;
    endtask

    // Load-result monitor: a request consumed by MEM (stall low) must see the model's word
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && mem_ce_i && |mem_sel_i && !exc_flush_i && !stall_req_o) begin
                if (exp_rd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rdata_unexpected: got %h expected no completion", rdata_o);
                end else begin
                    e = exp_rd.pop_front();
                    chk("rdata_o", rdata_o, e);
                end
            end
        end
    end

    // Bus slave: random or fixed addr_ok/data_ok delays, checks each accepted request
    initial begin : slave
        int          aok_cnt = -1, dok_cnt = 0;
        logic        out_valid = 1'b0, p_req = 1'b0, stable = 1'b1;
        logic [31:0] out_data = 32'b0;
        bus_t        p, first, cur, e;
        dbus_addr_ok_i = 1'b0; dbus_data_ok_i = 1'b0; dbus_rdata_i = 32'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                aok_cnt = -1; out_valid = 1'b0; p_req = 1'b0;
                dbus_addr_ok_i = 1'b0; dbus_data_ok_i = 1'b0; dbus_rdata_i = 32'b0;
            end else begin
                if (dbus_data_ok_i) out_valid = 1'b0;
                if (p_req && dbus_addr_ok_i) begin
                    chk("single_outstanding", 32'(out_valid), 32'd0);
                    chk("req_stable", 32'(stable), 32'd1);
                    if (exp_bus.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL bus_unexpected_req: got addr %h expected none", p.addr);
                    end else begin
                        e = exp_bus.pop_front();
                        chk("bus_addr", p.addr, e.addr);
                        chk("bus_wr", 32'(p.wr), 32'(e.wr));
                        chk("bus_wstrb", 32'(p.strb), 32'(e.strb));
                        if (e.wr) chk("bus_wdata", p.wdata & lane_mask(e.strb), e.wdata & lane_mask(e.strb));
                    end
                    if (p.wr) begin
                        smem[p.addr] = merge(sget(p.addr), p.wdata, p.strb);
                        out_data = $urandom;
                    end else out_data = sget(p.addr);
                    out_valid = 1'b1;
                    dok_cnt = dok_fix >= 0 ? dok_fix : $urandom_range(0, 3);
                    aok_cnt = -1;
                end
                dbus_data_ok_i = out_valid && dok_cnt == 0;
                if (out_valid && dok_cnt > 0) dok_cnt--;
                dbus_rdata_i = dbus_data_ok_i ? out_data : $urandom;
                cur.addr = dbus_addr_o; cur.wr = dbus_wr_o; cur.strb = dbus_wstrb_o; cur.wdata = dbus_wdata_o;
                if (dbus_req_o) begin
                    req_cycles++;
                    if (aok_cnt < 0) begin
                        aok_cnt = aok_fix >= 0 ? aok_fix : $urandom_range(0, 3);
                        first = cur; stable = 1'b1;
                    end else if (cur.addr !== first.addr || cur.wr !== first.wr ||
                                 cur.strb !== first.strb || cur.wdata !== first.wdata) stable = 1'b0;
                    dbus_addr_ok_i = aok_cnt == 0;
                    if (aok_cnt > 0) aok_cnt--;
                end else dbus_addr_ok_i = 1'b0;
                p_req = dbus_req_o; p = cur;
            end
        end
    end

    initial begin : main
        int          st, r0;
        bus_t        b;
        logic [3:0]  sels [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        logic [1:0]  offs [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
        int          k;
        logic [31:0] a;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_req", 32'(dbus_req_o), 32'd0);
        chk("rst_wr", 32'(dbus_wr_o), 32'd0);
        chk("rst_wstrb", 32'(dbus_wstrb_o), 32'd0);
        chk("rst_addr", dbus_addr_o, 32'd0);
        chk("rst_wdata", dbus_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        // LW, minimum latency
        rmem[32'h1000] = 32'hdeadbeef; smem[32'h1000] = 32'hdeadbeef;
        aok_fix = 0; dok_fix = 0; r0 = req_cycles;
        access(1'b0, 4'b1111, 32'h0000_1000, 32'h0, st);
        chk("lw_min_stall", 32'(st), 32'd3);
        chk("lw_min_req_cycles", 32'(req_cycles - r0), 32'd1);
        // SB to top byte lane, then read back the merged word
        access(1'b1, 4'b1000, 32'h0000_1003, 32'ha5c3_3c11, st);
`ifdef DMEM_WBUF_EN
        chk("sb_stall", 32'(st), 32'd2);
`else
        chk("sb_stall", 32'(st), 32'd3);
`endif
        access(1'b0, 4'b1111, 32'h0000_1000, 32'h0, st);
        // LW with addr_ok held off four cycles
        aok_fix = 4; r0 = req_cycles;
        access(1'b0, 4'b1111, 32'h0000_1004, 32'h0, st);
        chk("lw_slow_aok_stall", 32'(st), 32'd7);
        chk("lw_slow_aok_req_cycles", 32'(req_cycles - r0), 32'd5);
        // flush while a load is in WAIT
        aok_fix = 0; dok_fix = 3;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h0000_1008;
        b.addr = 32'h0000_1008; b.wr = 1'b0; b.strb = 4'b1111; b.wdata = 32'h0;
        exp_bus.push_back(b);
        repeat (2) begin @(posedge clk); #1; end
        exc_flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall_drop", 32'(stall_req_o), 32'd0);
        chk("flush_rdata_keep", rdata_o, last_rd);
        @(posedge clk); #1;
        exc_flush_i = 1'b0; dok_fix = 0;
        access(1'b0, 4'b1111, 32'h0000_100c, 32'h0, st);
        chk("post_flush_lw_stall", 32'(st), 32'd6);
        // misaligned request is never issued
        r0 = req_cycles;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b0000; mem_addr_i = 32'h0000_1001;
        repeat (3) begin
            @(negedge clk);
            chk("misaligned_stall", 32'(stall_req_o), 32'd0);
        end
        @(posedge clk); #1 mem_ce_i = 1'b0;
        chk("misaligned_req_cycles", 32'(req_cycles - r0), 32'd0);
        // async reset in the middle of a request
        aok_fix = 3;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h0000_1010;
        @(posedge clk); #3;
        rst = 1'b0; mem_ce_i = 1'b0; mem_sel_i = 4'b0;
        #1;
        chk("async_rst_req", 32'(dbus_req_o), 32'd0);
        chk("async_rst_stall", 32'(stall_req_o), 32'd0);
        last_rd = 32'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        // store then load to the same word, store data_ok delayed
        aok_fix = 0; dok_fix = 3;
        access(1'b1, 4'b1111, 32'h0000_1014, 32'h1234_5678, st);
`ifdef DMEM_WBUF_EN
        chk("sw_posted_stall", 32'(st), 32'd2);
`else
        chk("sw_stall", 32'(st), 32'd6);
`endif
        access(1'b0, 4'b1111, 32'h0000_1014, 32'h0, st);
`ifdef DMEM_WBUF_EN
        chk("lw_after_sw_stall", 32'(st), 32'd9);
`else
        chk("lw_after_sw_stall", 32'(st), 32'd6);
`endif
        // randomized mix of loads and stores
        aok_fix = -1; dok_fix = -1;
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 6);
            a = 32'h0000_2000 + 32'($urandom_range(0, 15)) * 4 + 32'(offs[k]);
            access(1'($urandom_range(0, 1)), sels[k], a, $urandom, st);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        repeat (10) @(posedge clk);
        chk("exp_bus_drained", 32'(exp_bus.size()), 32'd0);
        chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
